// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one synchronous FIFO between two producers.
// Grants are combinational ready signals; the FIFO write port is driven from registers.
// Grants are throttled by the full/almostfull flags and write acknowledges are checked.
module fifo_wr_arbiter #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned BURST_MAX  = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic [FIFO_WIDTH-1:0] data0,
  input  logic                  req1,
  input  logic [FIFO_WIDTH-1:0] data1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  fifo_wr_en,
  output logic [FIFO_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_full,
  input  logic                  fifo_almostfull,
  input  logic                  fifo_wr_ack,
  input  logic                  fifo_overflow,
  output logic [1:0]            owner,
  output logic [CNT_W-1:0]      gnt_cnt0,
  output logic [CNT_W-1:0]      gnt_cnt1,
  output logic                  err_noack,
  output logic                  err_overflow
);

  localparam int unsigned       BurstW   = $clog2(BURST_MAX + 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(BURST_MAX);
  localparam logic [BurstW-1:0] BurstOne = BurstW'(1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOwn0 = 2'b01,
    StOwn1 = 2'b10
  } state_e;

  state_e                state_q, state_d;
  logic [BurstW-1:0]     burst_cnt_q, burst_cnt_d;
  logic                  rr_ptr_q, rr_ptr_d;
  logic                  fifo_wr_en_q;
  logic [FIFO_WIDTH-1:0] fifo_data_in_q;
  logic [CNT_W-1:0]      gnt_cnt0_q, gnt_cnt1_q;
  logic                  ack_pend_q;
  logic                  err_noack_q, err_overflow_q;

  logic                  slot;
  logic                  grant0, grant1;
  logic [BurstW-1:0]     burst_inc;

  // A write already in flight will consume the last slot flagged by almostfull.
  assign slot      = !fifo_full && !(fifo_almostfull && fifo_wr_en_q);
  assign burst_inc = (burst_cnt_q < BurstMax) ? burst_cnt_q + BurstOne : BurstMax;

  // Grant selection and ownership next-state; grants are only issued with the matching request.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    grant0      = 1'b0;
    grant1      = 1'b0;
    if (rst_n && slot) begin
      unique case (state_q)
        StIdle: begin
          if (req0 && (!req1 || !rr_ptr_q)) begin
            grant0      = 1'b1;
            state_d     = StOwn0;
            burst_cnt_d = BurstOne;
          end else if (req1) begin
            grant1      = 1'b1;
            state_d     = StOwn1;
            burst_cnt_d = BurstOne;
          end
        end
        StOwn0: begin
          if (req0 && (burst_cnt_q < BurstMax || !req1)) begin
            grant0      = 1'b1;
            burst_cnt_d = burst_inc;
          end else if (req1) begin
            grant1      = 1'b1;
            state_d     = StOwn1;
            burst_cnt_d = BurstOne;
            rr_ptr_d    = 1'b0;
          end else begin
            state_d  = StIdle;
            rr_ptr_d = 1'b1;
          end
        end
        StOwn1: begin
          if (req1 && (burst_cnt_q < BurstMax || !req0)) begin
            grant1      = 1'b1;
            burst_cnt_d = burst_inc;
          end else if (req0) begin
            grant0      = 1'b1;
            state_d     = StOwn0;
            burst_cnt_d = BurstOne;
            rr_ptr_d    = 1'b1;
          end else begin
            state_d  = StIdle;
            rr_ptr_d = 1'b0;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      burst_cnt_q <= '0;
      rr_ptr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // Registered FIFO write port: the granted word is written one cycle after the grant edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_wr_en_q   <= 1'b0;
      fifo_data_in_q <= '0;
    end else begin
      fifo_wr_en_q <= grant0 | grant1;
      if (grant0) begin
        fifo_data_in_q <= data0;
      end else if (grant1) begin
        fifo_data_in_q <= data1;
      end
    end
  end

  // Per-requester transfer counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      if (grant0) gnt_cnt0_q <= gnt_cnt0_q + CNT_W'(1);
      if (grant1) gnt_cnt1_q <= gnt_cnt1_q + CNT_W'(1);
    end
  end

  // Sticky error flags; reset also discards any write still awaiting its acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_pend_q     <= 1'b0;
      err_noack_q    <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      ack_pend_q <= fifo_wr_en_q;
      if (ack_pend_q && !fifo_wr_ack) err_noack_q <= 1'b1;
      if (fifo_overflow) err_overflow_q <= 1'b1;
    end
  end

  assign gnt0         = grant0;
  assign gnt1         = grant1;
  assign fifo_wr_en   = fifo_wr_en_q;
  assign fifo_data_in = fifo_data_in_q;
  assign owner        = 2'(state_q);
  assign gnt_cnt0     = gnt_cnt0_q;
  assign gnt_cnt1     = gnt_cnt1_q;
  assign err_noack    = err_noack_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: hand-written vector table, directed corner sequences and
// randomized traffic against a behavioural FIFO and arbitration model.
module tb_fifo_wr_arbiter;

  localparam int W     = 16;
  localparam int BURST = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1;
  logic [W-1:0]  data0, data1;
  logic          gnt0, gnt1;
  logic          fifo_wr_en;
  logic [W-1:0]  fifo_data_in;
  logic          fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow;
  logic [1:0]    owner;
  logic [CW-1:0] gnt_cnt0, gnt_cnt1;
  logic          err_noack, err_overflow;

  fifo_wr_arbiter #(
    .FIFO_WIDTH(W),
    .BURST_MAX (BURST),
    .CNT_W     (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req0           (req0),
    .data0          (data0),
    .req1           (req1),
    .data1          (data1),
    .gnt0           (gnt0),
    .gnt1           (gnt1),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_data_in   (fifo_data_in),
    .fifo_full      (fifo_full),
    .fifo_almostfull(fifo_almostfull),
    .fifo_wr_ack    (fifo_wr_ack),
    .fifo_overflow  (fifo_overflow),
    .owner          (owner),
    .gnt_cnt0       (gnt_cnt0),
    .gnt_cnt1       (gnt_cnt1),
    .err_noack      (err_noack),
    .err_overflow   (err_overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Environment: FIFO model (use_model=1) or directly driven flags (use_model=0).
  logic [W-1:0] fq[$];
  logic [W-1:0] wlog[$];
  int   depth       = 8;
  logic rd_mode     = 1'b0;
  logic use_model   = 1'b1;
  logic force_noack = 1'b0;

  // Reference model of the arbitration rules. Owner -1 means nobody owns the port.
  logic         m_valid = 1'b0;
  int           m_owner = -1;
  int           m_run   = 0;
  int           m_pref  = 0;
  logic         m_wr_en = 1'b0;
  logic [W-1:0] m_data  = '0;
  logic [CW-1:0] m_cnt[2];
  logic         m_ack_pend = 1'b0;
  logic         m_err_noack = 1'b0;
  logic         m_err_ovf = 1'b0;
  int           wait_cnt[2];

  // Values observed in the most recent cycle.
  logic         s_rst, s_gnt0, s_gnt1, s_wr_en, s_af;
  logic [W-1:0] s_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic r0, input logic r1);
    logic r[2];
    int   x;
    r[0] = r0;
    r[1] = r1;
    if (m_owner < 0) begin
      if (r0 && r1) return m_pref;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
    end
    x = m_owner;
    if (r[x] && (m_run < BURST || !r[1-x])) return x;
    if (r[1-x]) return 1 - x;
    return -1;
  endfunction

  // One clock cycle: check outputs mid-cycle, then advance model and environment after the edge.
  task automatic cycle();
    int           win, cnt_before;
    logic         slot, s_ack, s_ovf, s_req0, s_req1, acc, ovf;
    logic [W-1:0] s_d0, s_d1, tmp;
    logic [1:0]   exp_owner;
    @(negedge clk);
    s_rst  = rst_n;   s_gnt0 = gnt0;          s_gnt1  = gnt1;
    s_wr_en = fifo_wr_en; s_data = fifo_data_in; s_af = fifo_almostfull;
    s_ack  = fifo_wr_ack; s_ovf = fifo_overflow;
    s_req0 = req0; s_req1 = req1; s_d0 = data0; s_d1 = data1;
    slot = !fifo_full && !(fifo_almostfull && m_wr_en);
    win = -1;
    if (rst_n && slot) win = pick(req0, req1);
    chk("gnt0", gnt0, win == 0);
    chk("gnt1", gnt1, win == 1);
    chk("gnt_exclusive", gnt0 & gnt1, 0);
    chk("gnt_without_req", (gnt0 & !req0) | (gnt1 & !req1), 0);
    if (gnt0) chk("fairness0", wait_cnt[0] <= BURST, 1);
    if (gnt1) chk("fairness1", wait_cnt[1] <= BURST, 1);
    if (m_valid) begin
      exp_owner = (m_owner < 0) ? 2'd0 : ((m_owner == 0) ? 2'd1 : 2'd2);
      chk("owner", owner, exp_owner);
      chk("fifo_wr_en", fifo_wr_en, m_wr_en);
      chk("fifo_data_in", fifo_data_in, m_data);
      chk("gnt_cnt0", gnt_cnt0, m_cnt[0]);
      chk("gnt_cnt1", gnt_cnt1, m_cnt[1]);
      chk("err_noack", err_noack, m_err_noack);
      chk("err_overflow", err_overflow, m_err_ovf);
    end
    @(posedge clk);
    #1;
    if (!s_rst) begin
      m_valid = 1'b1; m_owner = -1; m_run = 0; m_pref = 0;
      m_wr_en = 1'b0; m_data = '0; m_cnt[0] = '0; m_cnt[1] = '0;
      m_ack_pend = 1'b0; m_err_noack = 1'b0; m_err_ovf = 1'b0;
      wait_cnt[0] = 0; wait_cnt[1] = 0;
    end else begin
      if (m_ack_pend && !s_ack) m_err_noack = 1'b1;
      m_ack_pend = m_wr_en;
      if (s_ovf) m_err_ovf = 1'b1;
      m_wr_en = (win >= 0);
      if (win >= 0) begin
        m_data = (win == 1) ? s_d1 : s_d0;
        m_cnt[win] = m_cnt[win] + 1'b1;
      end
      if (slot) begin
        if (win < 0) begin
          if (m_owner >= 0) begin
            m_pref  = 1 - m_owner;
            m_owner = -1;
          end
        end else if (win == m_owner) begin
          m_run = (m_run < BURST) ? m_run + 1 : BURST;
        end else begin
          if (m_owner >= 0) m_pref = m_owner;
          m_owner = win;
          m_run   = 1;
        end
        wait_cnt[0] = (s_req0 && !s_gnt0) ? wait_cnt[0] + 1 : 0;
        wait_cnt[1] = (s_req1 && !s_gnt1) ? wait_cnt[1] + 1 : 0;
      end
    end
    if (use_model) begin
      cnt_before = fq.size();
      acc = 1'b0;
      ovf = 1'b0;
      if (s_wr_en) begin
        if (cnt_before < depth) begin
          fq.push_back(s_data);
          wlog.push_back(s_data);
          acc = 1'b1;
        end else begin
          ovf = 1'b1;
        end
      end
      if (rd_mode && cnt_before > 0) tmp = fq.pop_front();
      fifo_wr_ack     = acc && !force_noack;
      fifo_overflow   = ovf;
      fifo_full       = (fq.size() >= depth);
      fifo_almostfull = (fq.size() == depth - 1);
    end else begin
      fifo_wr_ack   = s_wr_en && !force_noack;
      fifo_overflow = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    fq.delete();
    wlog.delete();
    fifo_full = 1'b0; fifo_almostfull = 1'b0; fifo_wr_ack = 1'b0; fifo_overflow = 1'b0;
  endtask

  typedef struct packed {
    logic r0;
    logic r1;
    logic full;
    logic af;
    logic g0;
    logic g1;
  } vec_t;

  vec_t         vecs[20];
  logic [W-1:0] t1_data[3];
  int           gcount, af_seen;

  initial begin
    // Columns: req0 req1 full almostfull | expected gnt0 gnt1 (starting from reset)
    vecs[0]  = 6'b1100_10;  vecs[1]  = 6'b1100_10;  vecs[2]  = 6'b1100_10;
    vecs[3]  = 6'b1100_10;  vecs[4]  = 6'b1100_01;  vecs[5]  = 6'b1110_00;
    vecs[6]  = 6'b1101_01;  vecs[7]  = 6'b1101_00;  vecs[8]  = 6'b0100_01;
    vecs[9]  = 6'b0000_00;  vecs[10] = 6'b1100_10;  vecs[11] = 6'b0100_01;
    vecs[12] = 6'b0000_00;  vecs[13] = 6'b0100_01;  vecs[14] = 6'b0000_00;
    vecs[15] = 6'b1000_10;  vecs[16] = 6'b0000_00;  vecs[17] = 6'b1100_01;
    vecs[18] = 6'b1100_01;  vecs[19] = 6'b1000_10;

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    fifo_full = 1'b0; fifo_almostfull = 1'b0; fifo_wr_ack = 1'b0; fifo_overflow = 1'b0;
    m_cnt[0] = '0; m_cnt[1] = '0; wait_cnt[0] = 0; wait_cnt[1] = 0;

    do_reset();
    chk("reset_owner", owner, 2'd0);
    chk("reset_wr_en", fifo_wr_en, 0);
    chk("reset_data", fifo_data_in, 0);
    chk("reset_cnt0", gnt_cnt0, 0);
    chk("reset_errs", {err_noack, err_overflow}, 0);

    // Vector table with flags driven directly.
    use_model = 1'b0;
    for (int i = 0; i < 20; i++) begin
      req0 = vecs[i].r0; req1 = vecs[i].r1;
      fifo_full = vecs[i].full; fifo_almostfull = vecs[i].af;
      data0 = W'(16'hA000 + i); data1 = W'(16'hB000 + i);
      cycle();
      chk($sformatf("tbl%0d_gnt0", i), s_gnt0, vecs[i].g0);
      chk($sformatf("tbl%0d_gnt1", i), s_gnt1, vecs[i].g1);
    end

    // T1: single requester, three words into an empty FIFO.
    use_model = 1'b1; depth = 8; rd_mode = 1'b0;
    do_reset();
    t1_data[0] = 16'h0011; t1_data[1] = 16'h0022; t1_data[2] = 16'h0033;
    gcount = 0;
    for (int k = 0; k < 6; k++) begin
      req0  = (k < 3);
      data0 = (k < 3) ? t1_data[k] : '0;
      cycle();
      gcount += int'(s_gnt0);
    end
    chk("t1_grants", gcount, 3);
    chk("t1_writes", wlog.size(), 3);
    for (int k = 0; k < 3; k++) chk($sformatf("t1_word%0d", k), wlog[k], t1_data[k]);
    chk("t1_gnt_cnt0", gnt_cnt0, 3);
    chk("t1_owner_idle", owner, 2'd0);

    // T2: continuous contention with the FIFO drained every cycle.
    do_reset();
    rd_mode = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cycle();
      chk($sformatf("t2_pat%0d", k), {s_gnt1, s_gnt0}, ((k / BURST) % 2 == 1) ? 2'b10 : 2'b01);
      if (s_gnt0) data0 = W'($urandom);
      if (s_gnt1) data1 = W'($urandom);
    end

    // T3/T4: depth-8 FIFO with no reads; almostfull with a write in flight blocks the grant.
    do_reset();
    rd_mode = 1'b0; depth = 8;
    req0 = 1'b1; req1 = 1'b0;
    gcount = 0; af_seen = 0;
    for (int k = 0; k < 12; k++) begin
      data0 = W'(16'h0100 + k);
      cycle();
      gcount += int'(s_gnt0);
      if (s_af && s_wr_en) begin
        af_seen++;
        chk("t4_af_inflight_nogrant", s_gnt0, 0);
      end
    end
    chk("t3_grants", gcount, 8);
    chk("t3_fifo_level", fq.size(), 8);
    chk("t3_gnt_cnt0", gnt_cnt0, 8);
    chk("t3_err_overflow", err_overflow, 0);
    chk("t4_af_cycle_seen", af_seen > 0, 1);
    req0 = 1'b0;

    // Randomized traffic in three phases of differing FIFO depth.
    for (int p = 0; p < 3; p++) begin
      depth = 2 + p * 3;
      do_reset();
      for (int k = 0; k < 600; k++) begin
        rd_mode = ($urandom_range(0, 99) < 55);
        if (!req0 || s_gnt0) begin
          req0 = ($urandom_range(0, 99) < 70); data0 = W'($urandom);
        end
        if (!req1 || s_gnt1) begin
          req1 = ($urandom_range(0, 99) < 70); data1 = W'($urandom);
        end
        cycle();
      end
      req0 = 1'b0; req1 = 1'b0;
    end

    // T5: missing acknowledge raises err_noack two edges after the grant edge.
    depth = 8; rd_mode = 1'b1;
    do_reset();
    force_noack = 1'b1;
    req0 = 1'b1; data0 = 16'h5A5A;
    cycle();
    req0 = 1'b0;
    cycle();
    chk("t5_noack_not_yet", err_noack, 0);
    cycle();
    chk("t5_noack_set", err_noack, 1);
    for (int k = 0; k < 4; k++) cycle();
    chk("t5_noack_sticky", err_noack, 1);

    // Overflow flag from the FIFO is latched.
    use_model = 1'b0;
    fifo_overflow = 1'b1;
    cycle();
    chk("ovf_set", err_overflow, 1);
    for (int k = 0; k < 3; k++) cycle();
    chk("ovf_sticky", err_overflow, 1);

    // T6: reset during OWN1 with burst 2 and an unacknowledged write in flight.
    use_model = 1'b1;
    do_reset();
    chk("t6_errs_cleared", {err_noack, err_overflow}, 0);
    req1 = 1'b1; data1 = 16'hC001;
    cycle();
    data1 = 16'hC002;
    cycle();
    chk("t6_pre_owner", owner, 2'd2);
    rst_n = 1'b0; req1 = 1'b0;
    cycle();
    chk("t6_no_gnt_in_reset", s_gnt1, 0);
    rst_n = 1'b1;
    chk("t6_owner", owner, 2'd0);
    chk("t6_wr_en", fifo_wr_en, 0);
    chk("t6_cnts", {gnt_cnt0, gnt_cnt1}, 0);
    chk("t6_noack", err_noack, 0);
    cycle();
    cycle();
    chk("t6_noack_late", err_noack, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
